// File: rtl/bram_arb.sv
// bram_arb: shares one single-port sample BRAM between the ring-buffer writer
// and the filter-engine reader. One requester is granted at a time. Bursts are
// bounded to MAX_BURST while the other side waits, ties alternate round-robin,
// and read data comes back with a fixed RD_LAT cycle latency.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        asynchronous active-low reset
//   wr_req     writer request, held while words remain
//   wr_addr    write address
//   wr_data    write data
//   wr_gnt     write transfer occurs this cycle
//   rd_req     reader request
//   rd_addr    read address
//   rd_gnt     read transfer issued this cycle
//   rd_data    read data (straight from bram_dout)
//   rd_vld     rd_data valid for the read issued RD_LAT cycles earlier
//   bram_we    BRAM write enable
//   bram_addr  BRAM address
//   bram_din   BRAM write data
//   bram_dout  BRAM read data
module bram_arb #(
   parameter int ADDR_SIZE = 5,
   parameter int DATA_SIZE = 12,
   parameter int MAX_BURST = 4,
   parameter int RD_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_req,
   input  logic [ADDR_SIZE-1:0] wr_addr,
   input  logic [DATA_SIZE-1:0] wr_data,
   output logic                 wr_gnt,
   input  logic                 rd_req,
   input  logic [ADDR_SIZE-1:0] rd_addr,
   output logic                 rd_gnt,
   output logic [DATA_SIZE-1:0] rd_data,
   output logic                 rd_vld,
   output logic                 bram_we,
   output logic [ADDR_SIZE-1:0] bram_addr,
   output logic [DATA_SIZE-1:0] bram_din,
   input  logic [DATA_SIZE-1:0] bram_dout
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_RD   = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [CNT_W-1:0]  cnt_inc;
   // 1 when the reader was the last side served; reset to 1 so the writer wins
   // the first tie.
   logic              last_rd_reg, last_rd_next;
   logic [RD_LAT-1:0] vld_sr_reg, vld_sr_next;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         last_rd_reg <= 1'b1;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         last_rd_reg <= last_rd_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      last_rd_next = last_rd_reg;
      cnt_inc      = cnt_reg + CNT_W'(1);
      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            if (wr_req && rd_req) begin
               state_next = last_rd_reg ? S_WR : S_RD;
            end else if (wr_req) begin
               state_next = S_WR;
            end else if (rd_req) begin
               state_next = S_RD;
            end
         end
         S_WR: begin
            if (wr_req) begin
               if (cnt_inc == CNT_MAX) begin
                  // Burst limit reached: hand over only if the reader waits,
                  // otherwise restart the count and keep writing.
                  cnt_next = '0;
                  if (rd_req) begin
                     state_next   = S_RD;
                     last_rd_next = 1'b0;
                  end
               end else begin
                  cnt_next = cnt_inc;
               end
            end else begin
               // Writer dropped: this cycle was the bubble.
               cnt_next     = '0;
               last_rd_next = 1'b0;
               state_next   = rd_req ? S_RD : S_IDLE;
            end
         end
         S_RD: begin
            if (rd_req) begin
               if (cnt_inc == CNT_MAX) begin
                  cnt_next = '0;
                  if (wr_req) begin
                     state_next   = S_WR;
                     last_rd_next = 1'b1;
                  end
               end else begin
                  cnt_next = cnt_inc;
               end
            end else begin
               cnt_next     = '0;
               last_rd_next = 1'b1;
               state_next   = wr_req ? S_WR : S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Output logic: grants and BRAM pin mux from the registered state
   always_comb begin
      wr_gnt    = 1'b0;
      rd_gnt    = 1'b0;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_din  = '0;
      case (state_reg)
         S_WR: begin
            wr_gnt    = wr_req;
            bram_we   = wr_req;
            bram_addr = wr_addr;
            bram_din  = wr_data;
         end
         S_RD: begin
            rd_gnt    = rd_req;
            bram_addr = rd_addr;
         end
         default: ;
      endcase
   end

   // Read-valid pipeline: keeps tracking reads issued before leaving RD.
   assign vld_sr_next[0] = rd_gnt;
   for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_vld
      assign vld_sr_next[gi] = vld_sr_reg[gi-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_sr_reg <= '0;
      end else begin
         vld_sr_reg <= vld_sr_next;
      end
   end

   assign rd_vld  = vld_sr_reg[RD_LAT-1];
   assign rd_data = bram_dout;

endmodule
